// File: rtl/mode_button_ctrl.sv
// Push-button front end: synchronises and debounces btn, then turns
// short presses into a cyclic mode step and long presses into mode 0.
module mode_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [1:0] mode,
    output logic       mode_chg
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(LONG_PRESS_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_e;

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           btn_db_q, btn_db_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    state_e         state_q, state_d;
    logic [15:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           mode_chg_q, mode_chg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            mode_q     <= 2'd0;
            mode_chg_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            mode_q     <= mode_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        mode_d     = mode_q;
        mode_chg_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_db_q) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                // hold_cnt lags one cycle, so the long strobe lands
                // exactly LONG_PRESS_CYCLES edges after btn_db rises
                if (!btn_db_q) begin
                    state_d    = IDLE;
                    mode_d     = mode_q + 2'd1;
                    mode_chg_d = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = LONG;
                    mode_d     = 2'd0;
                    mode_chg_d = 1'b1;
                end else if (hold_cnt_q != 16'hFFFF) begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            LONG: begin
                if (!btn_db_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mode     = mode_q;
    assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_mode_button_ctrl.sv
// Directed and random presses checked against a duration-based
// model of when each mode strobe must land and what mode results.
module tb_mode_button_ctrl;

    localparam int D = 4;
    localparam int L = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [1:0] mode;
    logic       mode_chg;

    int n_assert   = 0;
    int n_fail     = 0;
    int edge_n     = 0;
    int pulses     = 0;
    int last_pulse = -1;
    int exp_mode   = 0;

    always #5 clk = ~clk;

    mode_button_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .mode    (mode),
        .mode_chg(mode_chg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (mode_chg === 1'b1) begin
            pulses++;
            last_pulse = edge_n;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clean press: btn high for h edges, then low for g edges.
    // btn_db rises D+1 edges after the first edge that sees btn,
    // a short strobe follows one edge after btn_db falls, a long
    // strobe L edges after btn_db rises.
    task automatic press(input int h, input int g, input string tag);
        int p0;
        int e0;
        int exp_edge;
        p0  = pulses;
        btn = 1'b1;
        e0  = edge_n + 1;
        repeat (h) tick();
        btn = 1'b0;
        repeat (g) tick();
        if (h >= D) begin
            if (h >= L) begin
                exp_edge = e0 + D + 1 + L;
                exp_mode = 0;
            end else begin
                exp_edge = e0 + h + D + 2;
                exp_mode = (exp_mode + 1) % 4;
            end
            check({tag, "_npulse"}, pulses - p0, 1);
            check({tag, "_edge"}, last_pulse, exp_edge);
        end else begin
            check({tag, "_npulse"}, pulses - p0, 0);
        end
        check({tag, "_mode"}, {30'd0, mode}, exp_mode);
    endtask

    initial begin
        int p0;
        int h;
        int g;

        rst = 1'b1;
        btn = 1'b1;
        repeat (5) begin
            tick();
            check("rst_mode", {30'd0, mode}, 0);
            check("rst_chg", {31'd0, mode_chg}, 0);
        end
        check("rst_npulse", pulses, 0);
        rst = 1'b0;
        press(8, 8, "after_rst");

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_mode = 0;
        check("rst2_mode", {30'd0, mode}, 0);
        for (int i = 0; i < 4; i++) begin
            press(8, 8, "short");
        end

        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0);
            tick();
        end
        check("bounce_quiet", pulses - p0, 0);
        press(10, 10, "bounce");

        press(3, 10, "glitch");

        press(8, 8, "to_two");
        press(40, 8, "long");

        press(15, 10, "bound15");
        press(16, 10, "bound16");
        press(16, 10, "long_at0");

        press(8, 8, "pre_held");
        btn = 1'b1;
        repeat (D + 4) tick();
        rst = 1'b1;
        btn = 1'b0;
        p0  = pulses;
        repeat (3) tick();
        check("held_rst_mode", {30'd0, mode}, 0);
        rst = 1'b0;
        exp_mode = 0;
        repeat (12) tick();
        check("held_rst_npulse", pulses - p0, 0);
        check("held_rst_mode2", {30'd0, mode}, 0);

        for (int i = 0; i < 24; i++) begin
            h = $urandom_range(1, L + 8);
            g = $urandom_range(D + 4, D + 10);
            press(h, g, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
